// File: rtl/fsram_pkg.sv
// Shared constants for the feature-SRAM access paths (fill, drain, write-back).
package fsram_pkg;

    localparam int SRAM_NUM = 16;
    localparam int ADDR_W   = 12;
    localparam int WORD_W   = SRAM_NUM * 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [SRAM_NUM-1:0] WEN_READ = '1;

endpackage

// File: rtl/fsram_rd_fifo.sv
// Small synchronous FIFO with occupancy count; head word is presented combinationally.
module fsram_rd_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);
    import fsram_pkg::*;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsram_rd_drain.sv
// Feature-SRAM port-B drain engine: reads a block of consecutive words and streams
// them out over valid/ready, with read issue throttled by FIFO credits.
module fsram_rd_drain #(
    parameter int SRAM_NUM   = fsram_pkg::SRAM_NUM,
    parameter int ADDR_W     = fsram_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4,
    localparam int WORD_W    = SRAM_NUM * 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                CENB,
    output logic [SRAM_NUM-1:0] WENB,
    output logic [ADDR_W-1:0]   AB,
    input  logic [WORD_W-1:0]   QB,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                done
);
    import fsram_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              vld_p1;
    logic              vld_p2;
    logic              issue;
    logic              pop;
    logic              drained;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Reads still travelling toward the FIFO reserve a slot, so the FIFO can never overflow.
    function automatic logic has_credit(input logic [CNT_W-1:0] cnt, input logic p1,
                                        input logic p2, input logic popped);
        logic [CNT_W+1:0] used;
        used = (CNT_W+2)'(cnt) + (CNT_W+2)'(p1) + (CNT_W+2)'(p2) - (CNT_W+2)'(popped);
        return used < (CNT_W+2)'(FIFO_DEPTH);
    endfunction

    assign WENB       = '1;
    assign pop        = dout_valid && dout_ready;
    assign dout_valid = !fifo_empty;
    assign issue      = (state == ST_READ) && (remaining != '0)
                        && has_credit(fifo_count, vld_p1, vld_p2, pop);
    assign drained    = !vld_p1 && !vld_p2
                        && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    assign busy       = (state == ST_READ) || (state == ST_DRAIN);
    assign done       = (state == ST_FIN);

    // p0 -> p1: issue registers CENB/AB; p1 -> p2: SRAM access, QB valid in p2 and pushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            CENB      <= 1'b1;
            AB        <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
        end else begin
            CENB   <= !issue;
            vld_p1 <= issue;
            vld_p2 <= vld_p1;
            if (issue) begin
                AB        <= addr;
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= length;
                        // An empty block settles through DRAIN, whose exit test passes at once.
                        state     <= (length != '0) ? ST_READ : ST_DRAIN;
                    end
                end
                ST_READ: begin
                    if (remaining == '0) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fsram_rd_fifo #(
        .DATA_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p2),
        .wdata (QB),
        .pop   (pop),
        .rdata (dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fsram_rd_drain.sv
// Scoreboard bench for fsram_rd_drain: an SRAM array model, expected-word and
// expected-address queues filled at start time, and a monitor that checks every pop.
module tb_fsram_rd_drain;
    localparam int SRAM_NUM   = 16;
    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 4;
    localparam int WORD_W     = SRAM_NUM * 16;
    localparam int NWORDS     = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     length;
    logic                CENB;
    logic [SRAM_NUM-1:0] WENB;
    logic [ADDR_W-1:0]   AB;
    logic [WORD_W-1:0]   QB;
    logic [WORD_W-1:0]   dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    fsram_rd_drain #(
        .SRAM_NUM   (SRAM_NUM),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .CENB       (CENB),
        .WENB       (WENB),
        .AB         (AB),
        .QB         (QB),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    // SRAM model: one-cycle read latency
    logic [WORD_W-1:0] mem [NWORDS];
    always @(posedge clk) if (!CENB) QB <= mem[AB];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [WORD_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr[$];

    int  start_cyc = 0;
    int  first_valid_cyc = -1;
    int  last_pop_cyc = 0;
    int  done_cyc = 0;
    int  done_cnt = 0;
    int  pops = 0;
    int  lows = 0;
    int  max_out = 0;
    int  ready_mode = 0;
    bit  xfer_active = 0;
    bit  prev_stall = 0;
    logic [WORD_W-1:0] prev_dout;

    task automatic check_i(input string name, input int got, input int expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, expv, expv);
        end
    endtask

    task automatic check_w(input string name, input logic [WORD_W-1:0] got,
                           input logic [WORD_W-1:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    // Monitor: address order, credit bound, popped data, hold-under-stall, done legality
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            check_i("WENB", int'(WENB), (1 << SRAM_NUM) - 1);
            if (prev_stall) begin
                check_i("hold_valid", int'(dout_valid), 1);
                check_w("hold_dout", dout, prev_dout);
            end
            if (!CENB) begin
                lows++;
                if (exp_addr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL AB: read of 0x%0h issued, expected no read", AB);
                end else begin
                    check_i("AB", int'(AB), int'(exp_addr.pop_front()));
                end
                if (lows - pops > max_out) max_out = lows - pops;
                vectors++;
                if (lows - pops > FIFO_DEPTH) begin
                    miscompares++;
                    $display("FAIL credit: %0d words outstanding, limit %0d", lows - pops, FIFO_DEPTH);
                end
            end
            if (dout_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (dout_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL dout: got %0h, expected no word", dout);
                    end else begin
                        check_w("dout", dout, exp_q.pop_front());
                    end
                    pops++;
                    last_pop_cyc = cyc;
                end
            end
            if (done) begin
                check_i("done_expected", int'(xfer_active), 1);
                check_i("busy_at_done", int'(busy), 0);
                xfer_active = 1'b0;
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = low for cycles 3..10 after start
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = ($urandom_range(0, 99) < 65);
                default: dout_ready = !(((cyc - start_cyc) >= 3) && ((cyc - start_cyc) <= 10));
            endcase
        end
    end

    task automatic start_xfer(input int base, input int len, input bit accept);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base[ADDR_W-1:0];
        length    = len[ADDR_W:0];
        if (accept) begin
            start_cyc       = cyc;
            lows            = 0;
            pops            = 0;
            max_out         = 0;
            first_valid_cyc = -1;
            xfer_active     = 1'b1;
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(mem[ADDR_W'(base + i)]);
                exp_addr.push_back(ADDR_W'(base + i));
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n0;
        int t;
        n0 = done_cnt;
        t  = 0;
        while (done_cnt == n0 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == n0) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
            exp_q.delete();
            exp_addr.delete();
        end else begin
            check_i({name, "_drained"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int t;
        int base;
        int len;
        for (int a = 0; a < NWORDS; a++) begin
            logic [WORD_W-1:0] w;
            for (int k = 1; k < SRAM_NUM; k++) w[k*16 +: 16] = 16'($urandom);
            w[15:0] = 16'(a);
            mem[a] = w;
        end
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_i("rst_CENB", int'(CENB), 1);
        check_i("rst_WENB", int'(WENB), (1 << SRAM_NUM) - 1);
        check_i("rst_AB", int'(AB), 0);
        check_i("rst_valid", int'(dout_valid), 0);
        check_w("rst_dout", dout, '0);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic: latency, back-to-back words, done timing
        start_xfer('h010, 4, 1);
        @(negedge clk);
        check_i("basic_busy", int'(busy), 1);
        wait_done(60, "basic");
        check_i("basic_pops", pops, 4);
        check_i("basic_first_valid", first_valid_cyc - start_cyc, 4);
        check_i("basic_back_to_back", last_pop_cyc - first_valid_cyc, 3);
        check_i("basic_done_after_pop", done_cyc - last_pop_cyc, 1);

        // Backpressure: credits fill the FIFO exactly, nothing more
        ready_mode = 2;
        start_xfer('h020, 8, 1);
        wait_done(120, "backpressure");
        check_i("bp_pops", pops, 8);
        check_i("bp_max_outstanding", max_out, FIFO_DEPTH);
        ready_mode = 0;

        // Address wrap
        start_xfer('hFFE, 4, 1);
        wait_done(60, "wrap");
        check_i("wrap_reads", lows, 4);
        check_i("wrap_pops", pops, 4);

        // Zero length
        start_xfer('h123, 0, 1);
        wait_done(20, "zero");
        check_i("zero_reads", lows, 0);
        check_i("zero_done_latency", done_cyc - start_cyc, 2);

        // Reset in the middle of a transfer
        start_xfer('h080, 10, 1);
        t = 0;
        while (pops < 3 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check_i("midrst_pops_before", pops, 3);
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr.delete();
        xfer_active = 1'b0;
        n0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_i("midrst_CENB", int'(CENB), 1);
        check_i("midrst_valid", int'(dout_valid), 0);
        check_i("midrst_busy", int'(busy), 0);
        check_i("midrst_done", int'(done), 0);
        repeat (8) @(posedge clk);
        #1;
        check_i("midrst_no_done", done_cnt, n0);
        start_xfer('h000, 2, 1);
        wait_done(40, "after_reset");
        check_i("after_reset_pops", pops, 2);

        // Start while busy is ignored
        ready_mode = 1;
        n0 = done_cnt;
        start_xfer('h040, 6, 1);
        repeat (2) @(posedge clk);
        start_xfer('h100, 5, 0);
        wait_done(200, "busy_start");
        check_i("busy_start_pops", pops, 6);
        repeat (10) @(posedge clk);
        #1;
        check_i("busy_start_single_done", done_cnt - n0, 1);

        // Randomized transfers, alternating random and full-rate consumers
        for (int r = 0; r < 12; r++) begin
            ready_mode = r % 2;
            base = $urandom_range(0, NWORDS - 1);
            len  = $urandom_range(0, 24);
            start_xfer(base, len, 1);
            wait_done(len * 30 + 60, "random");
            check_i("random_pops", pops, len);
            if (len > 0) begin
                check_i("random_done_after_pop", done_cyc - last_pop_cyc, 1);
                if (ready_mode == 0) check_i("random_full_rate", last_pop_cyc - first_valid_cyc, len - 1);
            end else begin
                check_i("random_zero_latency", done_cyc - start_cyc, 2);
            end
        end
        ready_mode = 0;

        repeat (5) @(posedge clk);
        #1;
        check_i("final_words_left", exp_q.size(), 0);
        check_i("final_reads_left", exp_addr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
